// File: rtl/audio_i2s_tx.sv
// Philips I2S transmitter: 64-bit frames (two 32-bit slots) fed by a valid/ready sample port.
// Build option AUDIO_I2S_UNDERRUN_MUTE_EN: underrun frames carry zeros instead of the last pair.
`timescale 1ns/1ps
module audio_i2s_tx #(
    parameter int SAMPLE_W = 16,
    parameter int BCLK_DIV = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pll_locked,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [SAMPLE_W-1:0] s_left,
    input  logic [SAMPLE_W-1:0] s_right,
    output logic                i2s_bclk,
    output logic                i2s_lrck,
    output logic                i2s_dat,
    output logic                frame_start,
    output logic                underrun
);

    localparam int DW = $clog2(BCLK_DIV);
    localparam logic [DW-1:0] DIV_MAX  = DW'(BCLK_DIV - 1);
    localparam logic [DW-1:0] DIV_HALF = DW'(BCLK_DIV / 2);

    typedef enum logic {IDLE, RUN} state_t;

    state_t state_q, state_d;

    logic                lock_m, lock_s;
    logic [DW-1:0]       div_q, div_d;
    logic [5:0]          bit_q, bit_d;
    logic [63:0]         sh_q, sh_d;
    logic                bclk_q, bclk_d;
    logic                lrck_q, lrck_d;
    logic                fs_q, fs_d;
    logic                ur_q, ur_d;
    logic                hold_full_q, hold_full_d;
    logic [SAMPLE_W-1:0] hold_l_q, hold_l_d;
    logic [SAMPLE_W-1:0] hold_r_q, hold_r_d;
    logic [SAMPLE_W-1:0] last_l_q, last_l_d;
    logic [SAMPLE_W-1:0] last_r_q, last_r_d;
    logic [SAMPLE_W-1:0] pick_l, pick_r;
    logic                boundary, load, xfer, run_en;

    function automatic logic [31:0] slot(input logic [SAMPLE_W-1:0] s);
        logic [31:0] t;
        t = '0;
        t[31 -: SAMPLE_W] = s;
        return t;
    endfunction

    assign s_ready     = (state_q == RUN) && !hold_full_q;
    assign xfer        = s_valid && s_ready;
    assign run_en      = (state_q == RUN) && lock_s;
    assign boundary    = (div_q == DIV_MAX);
    assign load        = run_en && boundary && (bit_q == 6'd63);

    assign i2s_bclk    = bclk_q;
    assign i2s_lrck    = lrck_q;
    assign i2s_dat     = sh_q[63];
    assign frame_start = fs_q;
    assign underrun    = ur_q;

    // Frame source: buffered pair, then same-cycle bypass, then underrun fill.
    always_comb begin
        pick_l = last_l_q;
        pick_r = last_r_q;
        if (hold_full_q) begin
            pick_l = hold_l_q;
            pick_r = hold_r_q;
        end else if (s_valid) begin
            pick_l = s_left;
            pick_r = s_right;
        end else begin
`ifdef AUDIO_I2S_UNDERRUN_MUTE_EN
            pick_l = '0;
            pick_r = '0;
`else
            pick_l = last_l_q;
            pick_r = last_r_q;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (lock_s) state_d = RUN;
            RUN:     if (!lock_s) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        div_d       = div_q;
        bit_d       = bit_q;
        sh_d        = sh_q;
        bclk_d      = bclk_q;
        lrck_d      = lrck_q;
        fs_d        = 1'b0;
        ur_d        = 1'b0;
        hold_full_d = hold_full_q;
        hold_l_d    = hold_l_q;
        hold_r_d    = hold_r_q;
        last_l_d    = last_l_q;
        last_r_d    = last_r_q;
        if (!run_en) begin
            div_d       = '0;
            bit_d       = 6'd63;
            sh_d        = '0;
            bclk_d      = 1'b0;
            lrck_d      = 1'b0;
            hold_full_d = 1'b0;
            hold_l_d    = '0;
            hold_r_d    = '0;
            last_l_d    = '0;
            last_r_d    = '0;
        end else begin
            div_d = boundary ? '0 : div_q + 1'b1;
            if (boundary) begin
                bit_d = bit_q + 6'd1;
                sh_d  = {sh_q[62:0], 1'b0};
            end
            if (load) begin
                sh_d     = {slot(pick_l), slot(pick_r)};
                fs_d     = 1'b1;
                ur_d     = !hold_full_q && !s_valid;
                last_l_d = pick_l;
                last_r_d = pick_r;
            end
            if (load && hold_full_q) begin
                hold_full_d = 1'b0;
            end else if (xfer && !load) begin
                hold_full_d = 1'b1;
                hold_l_d    = s_left;
                hold_r_d    = s_right;
            end
            bclk_d = (div_d >= DIV_HALF);
            lrck_d = (bit_d >= 6'd31) && (bit_d <= 6'd62);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lock_m      <= 1'b0;
            lock_s      <= 1'b0;
            state_q     <= IDLE;
            div_q       <= '0;
            bit_q       <= 6'd63;
            sh_q        <= '0;
            bclk_q      <= 1'b0;
            lrck_q      <= 1'b0;
            fs_q        <= 1'b0;
            ur_q        <= 1'b0;
            hold_full_q <= 1'b0;
            hold_l_q    <= '0;
            hold_r_q    <= '0;
            last_l_q    <= '0;
            last_r_q    <= '0;
        end else begin
            lock_m      <= pll_locked;
            lock_s      <= lock_m;
            state_q     <= state_d;
            div_q       <= div_d;
            bit_q       <= bit_d;
            sh_q        <= sh_d;
            bclk_q      <= bclk_d;
            lrck_q      <= lrck_d;
            fs_q        <= fs_d;
            ur_q        <= ur_d;
            hold_full_q <= hold_full_d;
            hold_l_q    <= hold_l_d;
            hold_r_q    <= hold_r_d;
            last_l_q    <= last_l_d;
            last_r_q    <= last_r_d;
        end
    end

endmodule

// File: tb/tb_audio_i2s_tx.sv
// Bench for audio_i2s_tx: frame-timing reference model, I2S receiver and table vectors.
`timescale 1ns/1ps
module tb_audio_i2s_tx;

`ifdef AUDIO_I2S_UNDERRUN_MUTE_EN
    localparam bit MUTE = 1'b1;
`else
    localparam bit MUTE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, pll_locked, s_valid, s_ready;
    logic [15:0] s_left, s_right;
    logic        i2s_bclk, i2s_lrck, i2s_dat, frame_start, underrun;

    always #5 clk = ~clk;

    audio_i2s_tx #(.SAMPLE_W(16), .BCLK_DIV(4)) dut (
        .clk(clk), .rst(rst), .pll_locked(pll_locked),
        .s_valid(s_valid), .s_ready(s_ready),
        .s_left(s_left), .s_right(s_right),
        .i2s_bclk(i2s_bclk), .i2s_lrck(i2s_lrck), .i2s_dat(i2s_dat),
        .frame_start(frame_start), .underrun(underrun)
    );

    typedef struct {
        logic [15:0] l;
        logic [15:0] r;
        logic [63:0] frame;
    } vec_t;

    vec_t tbl[4];

    int total = 0;
    int bad = 0;

    // driver / upstream
    logic [31:0] up_q[$];
    logic        drv_rst, drv_lock;

    // reference model: time since RUN entry plus a one-deep buffer
    bit          m_run, m_lk1, m_lk2, m_hfull, m_fs, m_ur;
    int          m_t;
    logic [31:0] m_hold, m_last, m_frame;

    // observation
    logic [5:0]  obs;
    int          n_cyc, n_ur, n_acc;
    int          seg_err, seg_cyc;
    logic [5:0]  seg_act, seg_exp;
    int          last_rise, bclk_per, last_fs, fs_per;
    logic        rx_prev;
    int          rx_cnt;
    logic [63:0] rx_w, rx_lr;
    logic [63:0] rx_q[$];
    logic [63:0] rxl_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic seg_check(input string name);
        total++;
        if (seg_err != 0) begin
            bad++;
            $display("FAIL %s: %0d cycle mismatches, first at cycle %0d got %b want %b",
                     name, seg_err, seg_cyc, seg_act, seg_exp);
        end
        seg_err = 0;
    endtask

    function automatic logic [5:0] exp_out();
        logic [63:0] fw;
        logic [5:0]  e;
        int          b;
        e = '0;
        if (m_run) begin
            b    = (m_t / 4 + 63) % 64;
            fw   = {m_frame[31:16], 16'h0, m_frame[15:0], 16'h0};
            e[5] = ((m_t % 4) >= 2);
            e[4] = (b >= 31) && (b <= 62);
            e[3] = fw[63-b];
            e[2] = m_fs;
            e[1] = m_ur;
            e[0] = !m_hfull;
        end
        return e;
    endfunction

    task automatic clear_model();
        m_hfull = 1'b0;
        m_hold  = '0;
        m_last  = '0;
        m_frame = '0;
        m_t     = 0;
    endtask

    task automatic model_edge();
        bit lk_now, rdy, xf;
        lk_now = m_lk2;
        rdy    = m_run && !m_hfull;
        xf     = s_valid && rdy;
        m_fs   = 1'b0;
        m_ur   = 1'b0;
        if (rst) begin
            m_run = 1'b0;
            m_lk1 = 1'b0;
            m_lk2 = 1'b0;
            clear_model();
        end else begin
            if (!m_run) begin
                clear_model();
                if (lk_now) m_run = 1'b1;
            end else if (!lk_now) begin
                m_run = 1'b0;
                clear_model();
            end else begin
                m_t++;
                if (m_t % 256 == 4) begin
                    m_fs = 1'b1;
                    if (m_hfull) begin
                        m_frame = m_hold;
                        m_hfull = 1'b0;
                    end else if (s_valid) begin
                        m_frame = {s_left, s_right};
                    end else begin
                        m_ur    = 1'b1;
                        m_frame = MUTE ? 32'h0 : m_last;
                    end
                    m_last = m_frame;
                end else if (xf) begin
                    m_hold  = {s_left, s_right};
                    m_hfull = 1'b1;
                end
            end
            m_lk2 = m_lk1;
            m_lk1 = pll_locked;
        end
        if (xf) void'(up_q.pop_front());
    endtask

    task automatic step();
        logic [5:0] e;
        @(negedge clk);
        n_cyc++;
        obs = {i2s_bclk, i2s_lrck, i2s_dat, frame_start, underrun, s_ready};
        e   = exp_out();
        if (obs !== e) begin
            if (seg_err == 0) begin
                seg_cyc = n_cyc;
                seg_act = obs;
                seg_exp = e;
            end
            seg_err++;
        end
        if (obs[1]) n_ur++;
        if (s_valid && s_ready) n_acc++;
        if (obs[2]) begin
            if (last_fs >= 0) fs_per = n_cyc - last_fs;
            last_fs = n_cyc;
            rx_cnt  = 0;
        end
        if (obs[5] && !rx_prev) begin
            if (last_rise >= 0) bclk_per = n_cyc - last_rise;
            last_rise = n_cyc;
            if (rx_cnt < 64) begin
                rx_w[63-rx_cnt]  = obs[3];
                rx_lr[63-rx_cnt] = obs[4];
                rx_cnt++;
                if (rx_cnt == 64) begin
                    rx_q.push_back(rx_w);
                    rxl_q.push_back(rx_lr);
                end
            end
        end
        rx_prev    = obs[5];
        rst        = drv_rst;
        pll_locked = drv_lock;
        s_valid    = (up_q.size() > 0);
        if (s_valid) {s_left, s_right} = up_q[0];
        else {s_left, s_right} = $urandom;
        model_edge();
        if (n_cyc % 256 == 0) seg_check("cycle_window");
    endtask

    task automatic wait_rx(input int n, input string name);
        for (int i = 0; i < 800 && rx_q.size() < n; i++) step();
        chk(name, 64'(rx_q.size() >= n), 64'd1);
    endtask

    task automatic wait_model_fs(input string name);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 300 && !got; i++) begin
            step();
            got = m_fs;
        end
        chk(name, 64'(got), 64'd1);
    endtask

    function automatic logic [63:0] rx_at(input int i);
        if (i < rx_q.size()) return rx_q[i];
        return 64'hx;
    endfunction

    function automatic logic [63:0] rxl_at(input int i);
        if (i < rxl_q.size()) return rxl_q[i];
        return 64'hx;
    endfunction

    initial begin
        int          entry, first_fs;
        bit          got;
        logic [31:0] pair;

        tbl[0] = '{16'hA5F0, 16'h0F0F, 64'hA5F00000_0F0F0000};
        tbl[1] = '{16'h0001, 16'h8000, 64'h00010000_80000000};
        tbl[2] = '{16'hFFFF, 16'h0000, 64'hFFFF0000_00000000};
        tbl[3] = '{16'h7FFF, 16'hFFFF, 64'h7FFF0000_FFFF0000};

        rst = 1'b1; pll_locked = 1'b0; s_valid = 1'b0;
        s_left = '0; s_right = '0;
        drv_rst = 1'b1; drv_lock = 1'b0;
        m_run = 1'b0; m_lk1 = 1'b0; m_lk2 = 1'b0; m_fs = 1'b0; m_ur = 1'b0;
        clear_model();
        n_cyc = 0; n_ur = 0; n_acc = 0; seg_err = 0; seg_cyc = 0;
        seg_act = '0; seg_exp = '0;
        last_rise = -1; bclk_per = 0; last_fs = -1; fs_per = 0;
        rx_prev = 1'b0; rx_cnt = 64; rx_w = '0; rx_lr = '0;

        repeat (2) @(posedge clk);
        repeat (3) step();
        chk("reset_outputs", 64'(obs), 64'd0);
        drv_rst = 1'b0;
        repeat (4) step();
        chk("idle_outputs", 64'(obs), 64'd0);

        // lock, first pair before the first load
        up_q.push_back({tbl[0].l, tbl[0].r});
        drv_lock = 1'b1;
        rx_q.delete(); rxl_q.delete();
        entry = -1; first_fs = -1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (entry < 0 && obs[0]) entry = i;
            if (first_fs < 0 && obs[2]) first_fs = i;
        end
        chk("run_latency", 64'(entry), 64'd3);
        chk("first_load_delay", 64'(first_fs - entry), 64'd4);
        wait_rx(1, "first_frame_wait");
        chk("first_frame_data", rx_at(0), tbl[0].frame);
        chk("first_frame_lrck", rxl_at(0), 64'h00000001_FFFFFFFE);
        chk("bclk_period", 64'(bclk_per), 64'd4);

        // table vectors, one pair per frame
        for (int k = 0; k < 4; k++) begin
            wait_model_fs("tbl_fs_wait");
            up_q.push_back({tbl[k].l, tbl[k].r});
            rx_q.delete(); rxl_q.delete();
            wait_rx(2, "tbl_rx_wait");
            chk($sformatf("tbl%0d_data", k), rx_at(1), tbl[k].frame);
            chk($sformatf("tbl%0d_lrck", k), rxl_at(1), 64'h00000001_FFFFFFFE);
        end
        chk("frame_period", 64'(fs_per), 64'd256);

        // starve the input: underrun every frame
        n_ur = 0;
        rx_q.delete(); rxl_q.delete();
        repeat (768) step();
        chk("underrun_count", 64'(n_ur), 64'd3);
        chk("underrun_data", rx_at(rx_q.size() - 1), MUTE ? 64'h0 : tbl[3].frame);

        // s_valid held high: one accept per frame once buffered
        for (int k = 0; k < 8; k++) up_q.push_back($urandom);
        got = 1'b0;
        for (int i = 0; i < 300 && !got; i++) begin
            step();
            got = obs[2];
        end
        chk("hold_fs_wait", 64'(got), 64'd1);
        for (int w = 0; w < 3; w++) begin
            n_acc = 0;
            step();
            chk($sformatf("ready_after_fill%0d", w), 64'(obs[0]), 64'd0);
            got = obs[2];
            for (int i = 0; i < 300 && !got; i++) begin
                step();
                got = obs[2];
            end
            chk($sformatf("accepts_per_frame%0d", w), 64'(n_acc), 64'd1);
        end
        up_q.delete();
        repeat (600) step();

        // bypass: first s_valid lands exactly on the load cycle
        got = 1'b0;
        for (int i = 0; i < 300 && !got; i++) begin
            got = m_run && (m_t % 256 == 3) && !m_hfull;
            if (!got) step();
        end
        chk("bypass_phase_wait", 64'(got), 64'd1);
        pair = 32'h1234_ABCD;
        up_q.push_back(pair);
        rx_q.delete(); rxl_q.delete();
        step();
        step();
        chk("bypass_fs", 64'(obs[2]), 64'd1);
        chk("bypass_no_underrun", 64'(obs[1]), 64'd0);
        chk("bypass_ready", 64'(obs[0]), 64'd1);
        chk("bypass_popped", 64'(up_q.size()), 64'd0);
        wait_rx(1, "bypass_rx_wait");
        chk("bypass_data", rx_at(0), {pair[31:16], 16'h0, pair[15:0], 16'h0});

        // lock loss in the right slot, then relock without data
        up_q.push_back(32'h5A5A_C3C3);
        repeat (600) step();
        got = 1'b0;
        for (int i = 0; i < 300 && !got; i++) begin
            got = m_run && (m_t % 256 == 164);
            if (!got) step();
        end
        chk("lockloss_phase_wait", 64'(got), 64'd1);
        drv_lock = 1'b0;
        n_ur = 0;
        step();
        repeat (3) step();
        chk("lockloss_outputs", 64'(obs), 64'd0);
        repeat (20) step();
        chk("lockloss_no_underrun", 64'(n_ur), 64'd0);
        drv_lock = 1'b1;
        rx_q.delete(); rxl_q.delete();
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            step();
            got = obs[2];
        end
        chk("relock_fs_wait", 64'(got), 64'd1);
        chk("relock_underrun", 64'(obs[1]), 64'd1);
        wait_rx(1, "relock_rx_wait");
        chk("relock_zero_data", rx_at(0), 64'h0);

        // random traffic with a lock drop and a mid-frame reset
        for (int i = 0; i < 4000; i++) begin
            if (i == 1500) drv_lock = 1'b0;
            if (i == 1540) drv_lock = 1'b1;
            if (i == 2700) drv_rst = 1'b1;
            if (i == 2702) drv_rst = 1'b0;
            if (up_q.size() < 2 && $urandom_range(0, 99) < 2) up_q.push_back($urandom);
            if (rx_q.size() > 16) begin
                rx_q.delete();
                rxl_q.delete();
            end
            step();
        end
        seg_check("final_window");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
